// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions for the decode stage: datapath sizes, opcode
// constants, instruction field positions and the immediate sign-extender.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  localparam logic [5:0] LW_OPC = 6'b100011;
  localparam logic [5:0] SW_OPC = 6'b101011;
  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] BEQ    = 6'b000100;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_W   = 16;

  // Sign-extend the 16-bit immediate field to the datapath width.
  function automatic logic [XLEN-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/idecode_if.sv
// Bus bundle around the decode stage.
//   IF side : IR, NPC, if_valid in; stall back to ifetch.
//   Control : flush squashes the instruction entering ID/EX.
//   WB side : wb_en, wb_addr, wb_data write port into the register bank.
//   EX side : A, B, Imm, IR_ex, NPC_ex, ex_valid (the ID/EX latch).
// slave is the decode stage, master is its environment.
interface idecode_if;
  import mips_pkg::*;

  logic [XLEN-1:0] IR;
  logic [XLEN-1:0] NPC;
  logic            if_valid;
  logic            flush;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] Imm;
  logic [XLEN-1:0] IR_ex;
  logic [XLEN-1:0] NPC_ex;
  logic            ex_valid;
  logic            stall;

  modport slave (
    input  IR, NPC, if_valid, flush, wb_en, wb_addr, wb_data,
    output A, B, Imm, IR_ex, NPC_ex, ex_valid, stall
  );

  modport master (
    output IR, NPC, if_valid, flush, wb_en, wb_addr, wb_data,
    input  A, B, Imm, IR_ex, NPC_ex, ex_valid, stall
  );
endinterface

// File: rtl/idecode_regbank.sv
// 32x32 register bank: two asynchronous read ports, one synchronous write
// port. R0 reads as zero and ignores writes. A same-cycle write to a nonzero
// read address is bypassed to the read data. Async clear on rst.
//   clk, rst        : clock, async active-high reset
//   ra1/ra2, rd1/rd2: read addresses and data
//   we, wa, wd      : write enable, address, data
module idecode_regbank
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_r [NREG];

  // Write port; R0 is never written so it stays at its cleared value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_r[wa] <= wd;
    end
  end

  // Read port 1: R0 forced to zero, else write-through bypass, else array.
  always_comb begin
    rd1 = '0;
    if (ra1 == 5'd0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[ra1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 == 5'd0) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[ra2];
    end
  end

endmodule

// File: rtl/idecode.sv
// MIPS32 instruction-decode stage. Reads rs/rt from the register bank,
// sign-extends the immediate and registers everything into the ID/EX latch.
// Detects load-use hazards against the load sitting in ID/EX and raises a
// combinational stall while inserting a bubble.
//   clk, rst : clock, async active-high reset
//   bus      : idecode_if.slave (IF inputs, WB write port, ID/EX outputs, stall)
module idecode
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  idecode_if.slave  bus
);

  logic [AW-1:0]   rs_s;
  logic [AW-1:0]   rt_s;
  logic [AW-1:0]   ld_rt_s;
  logic [XLEN-1:0] rs_data_s;
  logic [XLEN-1:0] rt_data_s;
  logic            stall_s;

  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] ir_ex_r;
  logic [XLEN-1:0] npc_ex_r;
  logic            ex_valid_r;

  assign rs_s    = bus.IR[RS_MSB:RS_LSB];
  assign rt_s    = bus.IR[RT_MSB:RT_LSB];
  assign ld_rt_s = ir_ex_r[RT_MSB:RT_LSB];

  idecode_regbank u_regbank (
    .clk (clk),
    .rst (rst),
    .ra1 (rs_s),
    .ra2 (rt_s),
    .rd1 (rs_data_s),
    .rd2 (rt_data_s),
    .we  (bus.wb_en),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

  // Load-use hazard: rt is compared for every format, so some non-readers of
  // rt stall needlessly; that costs a cycle but never correctness.
  always_comb begin
    stall_s = 1'b0;
    if (ex_valid_r && (ir_ex_r[OPC_MSB:OPC_LSB] == LW_OPC) &&
        (ld_rt_s != 5'd0) && bus.if_valid &&
        ((ld_rt_s == rs_s) || (ld_rt_s == rt_s))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // ID/EX latch. A bubble only rewrites IR_ex/ex_valid; the operand fields
  // keep their old contents since EX ignores them when ex_valid is low.
  // After a stall the load has left ID/EX, so the held IR proceeds next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= '0;
      b_r        <= '0;
      imm_r      <= '0;
      ir_ex_r    <= NOP;
      npc_ex_r   <= '0;
      ex_valid_r <= 1'b0;
    end else if (bus.flush || stall_s || !bus.if_valid) begin
      ir_ex_r    <= NOP;
      ex_valid_r <= 1'b0;
    end else begin
      a_r        <= rs_data_s;
      b_r        <= rt_data_s;
      imm_r      <= sign_ext(bus.IR[IMM_W-1:0]);
      ir_ex_r    <= bus.IR;
      npc_ex_r   <= bus.NPC;
      ex_valid_r <= 1'b1;
    end
  end

  assign bus.A        = a_r;
  assign bus.B        = b_r;
  assign bus.Imm      = imm_r;
  assign bus.IR_ex    = ir_ex_r;
  assign bus.NPC_ex   = npc_ex_r;
  assign bus.ex_valid = ex_valid_r;
  assign bus.stall    = stall_s;

endmodule
